// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue path: ALUctl encodings understood by the
// external 64-bit ALU, RV64 opcode values for the integer R/I formats, and the
// funct3 / funct7 / funct6 field values used to pick an operation.
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_XLEN    = 64;
   localparam int ALU_SHAMT_W = 6;

   // ALUctl codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRA = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;

   // Opcodes
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   // funct3 values
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct7 (R-type) and funct6 (I-type shift) qualifiers
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [5:0] F6_BASE = 6'b000000;
   localparam logic [5:0] F6_ALT  = 6'b010000;

endpackage

// File: rtl/alu_ctl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctl_decode
// Purely combinational decode of an RV64 R-type / I-type integer instruction
// into an ALUctl code and the B operand for the ALU.
// Ports:
//   instr   - 32-bit instruction word
//   rs2     - rs2 register value (used by R-type only)
//   ctl     - ALUctl code (ALU_AND when illegal)
//   b       - B operand value (zero when illegal)
//   rd      - destination register field
//   illegal - instruction is not one of the supported ALU operations
// ----------------------------------------------------------------------------
module alu_ctl_decode
   import alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int SHAMT_W = 6
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs2,
   output logic [3:0]      ctl,
   output logic [XLEN-1:0] b,
   output logic [4:0]      rd,
   output logic            illegal
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [5:0]      funct6;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] imm_shamt;
   logic [XLEN-1:0] rs2_shamt;
   logic            unused_rs1_field;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign funct6 = instr[31:26];
   assign rd     = instr[11:7];

   // rs1 index is resolved upstream at register read; only its value arrives.
   assign unused_rs1_field = ^instr[19:15];

   assign imm_sext  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_shamt = {{(XLEN-SHAMT_W){1'b0}}, instr[20+SHAMT_W-1:20]};
   assign rs2_shamt = {{(XLEN-SHAMT_W){1'b0}}, rs2[SHAMT_W-1:0]};

   always_comb begin
      ctl     = ALU_AND;
      b       = '0;
      illegal = 1'b0;

      case (opcode)
         OP_R: begin
            b = rs2;
            case (funct3)
               F3_ADD_SUB: begin
                  if (funct7 == F7_BASE)     ctl = ALU_ADD;
                  else if (funct7 == F7_ALT) ctl = ALU_SUB;
                  else                       illegal = 1'b1;
               end
               F3_AND: begin
                  ctl = ALU_AND;
                  illegal = (funct7 != F7_BASE);
               end
               F3_OR: begin
                  ctl = ALU_OR;
                  illegal = (funct7 != F7_BASE);
               end
               F3_XOR: begin
                  ctl = ALU_XOR;
                  illegal = (funct7 != F7_BASE);
               end
               F3_SLL: begin
                  ctl = ALU_SLL;
                  b   = rs2_shamt;
                  illegal = (funct7 != F7_BASE);
               end
               F3_SRL_SRA: begin
                  b = rs2_shamt;
                  if (funct7 == F7_BASE)     ctl = ALU_SRL;
                  else if (funct7 == F7_ALT) ctl = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_I: begin
            b = imm_sext;
            case (funct3)
               F3_ADD_SUB: ctl = ALU_ADD;   // no SUBI: funct7 is immediate here
               F3_AND:     ctl = ALU_AND;
               F3_OR:      ctl = ALU_OR;
               F3_XOR:     ctl = ALU_XOR;
               F3_SLL: begin
                  ctl = ALU_SLL;
                  b   = imm_shamt;
                  illegal = (funct6 != F6_BASE);
               end
               F3_SRL_SRA: begin
                  b = imm_shamt;
                  if (funct6 == F6_BASE)     ctl = ALU_SRL;
                  else if (funct6 == F6_ALT) ctl = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase

      // Illegal instructions present a quiet, all-zero ALU request.
      if (illegal) begin
         ctl = ALU_AND;
         b   = '0;
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// ----------------------------------------------------------------------------
// alu_issue_unit
// Initiator side of the external 64-bit ALU. Instructions with operand values
// arrive over a valid/ready handshake, are decoded into stage D (which drives
// the ALU straight from flops), and the ALU's combinational answer is caught
// in stage R and offered downstream with valid/ready. Full backpressure.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   in_valid/in_ready                - input handshake
//   in_instr, in_rs1, in_rs2         - instruction and operand values
//   alu_ctl, alu_a, alu_b            - request to the external ALU
//   alu_out, alu_zero                - combinational ALU response
//   out_valid/out_ready              - output handshake
//   out_result, out_zero, out_rd,
//   out_illegal                      - captured result fields
// ----------------------------------------------------------------------------
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = ALU_XLEN,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic [3:0]      alu_ctl,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_zero,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_zero,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   // Decoder outputs
   logic [3:0]      dec_ctl;
   logic [XLEN-1:0] dec_b;
   logic [4:0]      dec_rd;
   logic            dec_illegal;

   // Stage D
   logic            d_valid_q;
   logic [3:0]      d_ctl_q;
   logic [XLEN-1:0] d_a_q;
   logic [XLEN-1:0] d_b_q;
   logic [4:0]      d_rd_q;
   logic            d_illegal_q;

   // Stage R
   logic            r_valid_q;
   logic [XLEN-1:0] r_result_q;
   logic            r_zero_q;
   logic [4:0]      r_rd_q;
   logic            r_illegal_q;

   logic r_free;
   logic d_advance;
   logic accept;

   alu_ctl_decode #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_decode (
      .instr   (in_instr),
      .rs2     (in_rs2),
      .ctl     (dec_ctl),
      .b       (dec_b),
      .rd      (dec_rd),
      .illegal (dec_illegal)
   );

   assign r_free    = !r_valid_q || out_ready;
   assign d_advance = d_valid_q && r_free;
   assign in_ready  = !rst && (!d_valid_q || r_free);
   assign accept    = in_valid && in_ready;

   // Stage D: payload only changes on accept, so the ALU inputs hold steady
   // while D is empty or stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid_q   <= 1'b0;
         d_ctl_q     <= ALU_AND;
         d_a_q       <= '0;
         d_b_q       <= '0;
         d_rd_q      <= '0;
         d_illegal_q <= 1'b0;
      end else if (accept) begin
         d_valid_q   <= 1'b1;
         d_ctl_q     <= dec_ctl;
         d_a_q       <= dec_illegal ? '0 : in_rs1;
         d_b_q       <= dec_b;
         d_rd_q      <= dec_rd;
         d_illegal_q <= dec_illegal;
      end else if (d_advance) begin
         d_valid_q   <= 1'b0;
      end
   end

   // Stage R: capture the ALU answer for whatever D holds as it moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_q   <= 1'b0;
         r_result_q  <= '0;
         r_zero_q    <= 1'b0;
         r_rd_q      <= '0;
         r_illegal_q <= 1'b0;
      end else if (d_advance) begin
         r_valid_q   <= 1'b1;
         r_result_q  <= d_illegal_q ? '0 : alu_out;
         r_zero_q    <= d_illegal_q ? 1'b0 : alu_zero;
         r_rd_q      <= d_rd_q;
         r_illegal_q <= d_illegal_q;
      end else if (out_ready) begin
         r_valid_q   <= 1'b0;
      end
   end

   assign alu_ctl     = d_ctl_q;
   assign alu_a       = d_a_q;
   assign alu_b       = d_b_q;
   assign out_valid   = r_valid_q;
   assign out_result  = r_result_q;
   assign out_zero    = r_zero_q;
   assign out_rd      = r_rd_q;
   assign out_illegal = r_illegal_q;

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator side of the 64-bit ALU interface (4-bit ALUctl plus operands A and B, returning ALUOut and Zero).
- Accepts RV64 R-type and I-type integer instructions with operand values over a valid/ready handshake.
- Decodes each instruction to an ALUctl code, drives the external ALU from a registered stage, and captures ALUOut/Zero into a result register presented downstream with valid/ready.
- Two-stage pipeline with full backpressure; sits between register read and writeback.

Parameters:
XLEN, 64, datapath width; fixed to the ALU width, must not be overridden.
SHAMT_W, 6, shift-amount field width, $clog2(XLEN).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction/operands valid
in_ready  out  1  unit can accept this cycle
in_instr  in  32  instruction word
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value (ignored for I-type)
alu_ctl  out  4  to ALU ALUctl
alu_a  out  XLEN  to ALU A
alu_b  out  XLEN  to ALU B
alu_out  in  XLEN  from ALU ALUOut (combinational)
alu_zero  in  1  from ALU Zero
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_result  out  XLEN  captured result
out_zero  out  1  captured Zero
out_rd  out  5  destination register
out_illegal  out  1  instruction not supported

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- ALUctl codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRA 0110, SRL 0111.
- Opcode 0110011 (R), funct3 decode: 000 is ADD when funct7=0000000 and SUB when 0100000; 111 AND; 110 OR; 100 XOR; 001 SLL (funct7=0); 101 SRL (funct7=0) or SRA (0100000).
- Opcode 0010011 (I): same funct3 map, ADD only for 000 (no SUBI).
  - B = sign-extended instr[31:20].
  - Shifts: B = zero-extended instr[25:20]; instr[31:26] must be 000000 (SLLI/SRLI) or 010000 (SRAI).
- R-type shifts: B = zero-extended in_rs2[5:0]. Otherwise B = in_rs2. A = in_rs1 always.
- Illegal: any other opcode, funct3 010/011, or a bad funct7/funct6.
  - Decode stage drives alu_ctl=0000, alu_a=0, alu_b=0.
  - Result stage reports out_illegal=1, out_result=0, out_zero=0.
- Stage D (decode register: ctl, A, B, rd, illegal, d_valid) drives alu_* directly from flops; alu_* hold their value when D is empty or stalled.
- Stage R (result register: out_*) captures alu_out/alu_zero when D advances.
- Advance rules:
  - r_free = !out_valid || out_ready.
  - D advances into R when d_valid && r_free.
  - in_ready = !rst && (!d_valid || r_free), combinational.
  - Accept when in_valid && in_ready.
- Latency: input accepted at edge N gives alu_* valid during cycle N..N+1 and out_valid high after edge N+1. Throughput is 1 per cycle with out_ready held high.
- Backpressure: out_valid && !out_ready holds out_* stable. D holds if full. in_ready drops only when both stages are full. No drops, no duplicates, order preserved.
- Simultaneous accept in and release out in the same cycle is allowed at full rate.
- Reset, including mid-operation: d_valid=0, out_valid=0, alu_ctl=0000, alu_a=0, alu_b=0, out_result=0, out_zero=0, out_rd=0, out_illegal=0. In-flight items are discarded. in_ready is low during the reset cycle and high on the cycle after.
- in_valid has no effect while rst is high.

Decomposition:
- alu_pkg: ALUctl code localparams (AND..SRL above), opcode constants OP_R/OP_I, funct3 constants, funct7/funct6 constants.
- One sub-module, alu_ctl_decode: combinational. Inputs are instr, rs2 and imm paths. Outputs are ctl, B select/value, rd and illegal. The issue unit registers its outputs into stage D.

Test Plan:
- 0x002081B3 (add x3,x1,x2), rs1=5, rs2=3, out_ready=1 -> alu_ctl=0010; after 2 edges out_result=8, out_zero=0, out_rd=3.
- 0x402082B3 (sub x5,x1,x2), rs1=rs2=0x1234 -> alu_ctl=0011, out_result=0, out_zero=1, out_rd=5.
- 0x4020D313 (srai x6,x1,2), rs1=0xFFFFFFFFFFFFFFF0 -> alu_ctl=0110, alu_b=2, out_result=0xFFFFFFFFFFFFFFFC.
- 0x0020A1B3 (slt) -> out_illegal=1, out_result=0, alu_ctl=0000.
- Stream 4 ADDs with out_ready low for 3 cycles -> in_ready falls after 2 accepts, out_* stable while stalled, all 4 results delivered in order once out_ready rises.
- rst asserted with both stages full -> next cycle out_valid=0, alu_*=0; following a new add produces only its own result.
